// File: rtl/leaf_bft_packet_tx.sv
// Leaf-side BFT packet transmitter.
// Packs a valid/ready payload stream into 49-bit BFT packets, keeps every
// un-acked packet in a replay ring, and retransmits the un-acked window
// (oldest first, original sequence numbers) on a resend request.
module leaf_bft_packet_tx #(
  parameter int PAYLOAD_W    = 32,
  parameter int ADDR_W       = 5,
  parameter int PORT_W       = 3,
  parameter int SEQ_W        = 8,
  parameter int REPLAY_DEPTH = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      ap_start,
  input  logic [PAYLOAD_W-1:0]                      s_data,
  input  logic [ADDR_W-1:0]                         s_dest_leaf,
  input  logic [PORT_W-1:0]                         s_dest_port,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic                                      out_accept,
  output logic [ADDR_W+PORT_W+SEQ_W+PAYLOAD_W:0]    dout_leaf_interface2bft,
  input  logic                                      ack_valid,
  input  logic [SEQ_W-1:0]                          ack_seq,
  input  logic                                      resend,
  output logic [$clog2(REPLAY_DEPTH):0]             inflight
);

  localparam int PW = $clog2(REPLAY_DEPTH);
  localparam int EW = ADDR_W + PORT_W + SEQ_W + PAYLOAD_W;

  typedef enum logic {SEND, REPLAY} state_t;

  logic [EW-1:0]    r_ring [REPLAY_DEPTH];
  // Pointers carry one extra wrap bit so tail-head spans 0..REPLAY_DEPTH.
  logic [PW:0]      r_head;
  logic [PW:0]      r_tail;
  logic [PW:0]      r_send_ptr;
  logic [PW:0]      r_replay_end;
  logic [SEQ_W-1:0] r_next_seq;
  logic             r_pend;
  state_t           r_state;
  logic [EW:0]      r_dout;

  logic [PW:0]      w_inflight;
  logic             w_full;
  logic             w_accept;
  logic [SEQ_W-1:0] w_head_seq;
  logic [SEQ_W-1:0] w_off;
  logic [PW:0]      w_sent;
  logic             w_ack_ok;
  logic [PW:0]      w_head_new;
  logic [PW:0]      w_tail_new;
  logic             w_free;
  logic             w_rewind;
  logic [PW:0]      w_ptr_eff;
  logic             w_load;
  logic [EW-1:0]    w_new_entry;
  logic [EW-1:0]    w_load_entry;

  // Handshake, ack window, rewind and output-load decisions for this cycle.
  always_comb begin
    w_inflight  = r_tail - r_head;
    w_full      = (w_inflight == (PW+1)'(REPLAY_DEPTH));
    s_ready     = reset & ap_start & ~w_full & (r_state == SEND);
    w_accept    = s_valid & s_ready;
    // Ring entries carry consecutive seqs, so the head seq follows from next_seq.
    w_head_seq  = r_next_seq - SEQ_W'(w_inflight);
    w_off       = ack_seq - w_head_seq;
    w_sent      = r_send_ptr - r_head;
    w_ack_ok    = ack_valid & (w_off < SEQ_W'(w_sent));
    w_head_new  = w_ack_ok ? (r_head + w_off[PW:0] + (PW+1)'(1)) : r_head;
    w_tail_new  = r_tail + (PW+1)'(w_accept);
    w_free      = ~r_dout[EW] | out_accept;
    // A rewind waits for the held packet to be taken, then restarts at the post-ack head.
    w_rewind    = (resend | r_pend) & w_free;
    w_ptr_eff   = w_rewind ? w_head_new : r_send_ptr;
    w_load      = w_free & (w_ptr_eff != w_tail_new);
    w_new_entry = {s_dest_leaf, s_dest_port, r_next_seq, s_data};
    // Bypass lets a payload accepted this cycle load directly into the output register.
    w_load_entry = (w_ptr_eff == r_tail) ? w_new_entry : r_ring[w_ptr_eff[PW-1:0]];
    inflight                = w_inflight;
    dout_leaf_interface2bft = r_dout;
  end

  // Replay ring storage; contents are meaningless outside head..tail.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ring[r_tail[PW-1:0]] <= w_new_entry;
    end
  end

  // Pointers, output register and SEND/REPLAY state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_send_ptr   <= '0;
      r_replay_end <= '0;
      r_next_seq   <= '0;
      r_pend       <= 1'b0;
      r_state      <= SEND;
      r_dout       <= '0;
    end else begin
      r_head <= w_head_new;
      r_tail <= w_tail_new;
      if (w_accept) begin
        r_next_seq <= r_next_seq + SEQ_W'(1);
      end
      r_pend <= (resend | r_pend) & ~w_free;
      if (w_load) begin
        r_dout     <= {1'b1, w_load_entry};
        r_send_ptr <= w_ptr_eff + (PW+1)'(1);
      end else begin
        r_send_ptr <= w_ptr_eff;
        if (out_accept) begin
          r_dout[EW] <= 1'b0;
        end
      end
      case (r_state)
        SEND: begin
          if (resend) begin
            r_state      <= REPLAY;
            r_replay_end <= w_tail_new;
          end
        end
        REPLAY: begin
          if (resend) begin
            r_replay_end <= w_tail_new;
          end else if (!r_pend && (r_send_ptr == r_replay_end)) begin
            r_state <= SEND;
          end
        end
        default: r_state <= SEND;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_bft_packet_tx.sv
// Self-checking bench for leaf_bft_packet_tx: directed scenarios followed by
// randomized traffic, compared each cycle against a queue/ID-based model.
`timescale 1ns/1ps
module tb_leaf_bft_packet_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        ap_start;
  logic [31:0] s_data;
  logic [4:0]  s_dest_leaf;
  logic [2:0]  s_dest_port;
  logic        s_valid;
  logic        s_ready;
  logic        out_accept;
  logic [48:0] dout;
  logic        ack_valid;
  logic [7:0]  ack_seq;
  logic        resend;
  logic [3:0]  inflight;

  always #5 clk = ~clk;

  leaf_bft_packet_tx #(.REPLAY_DEPTH(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .ap_start                (ap_start),
    .s_data                  (s_data),
    .s_dest_leaf             (s_dest_leaf),
    .s_dest_port             (s_dest_port),
    .s_valid                 (s_valid),
    .s_ready                 (s_ready),
    .out_accept              (out_accept),
    .dout_leaf_interface2bft (dout),
    .ack_valid               (ack_valid),
    .ack_seq                 (ack_seq),
    .resend                  (resend),
    .inflight                (inflight)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: packets are numbered by an absolute id since reset;
  // seq = id mod 256. m_head = oldest un-acked id, m_tail = next id to accept,
  // m_send = next id to put on the link, m_end = id that closes a replay.
  logic [39:0] m_mem [0:1023];
  int          m_head, m_tail, m_send, m_end;
  bit          m_replay, m_pend, m_vld, m_acc;
  logic [47:0] m_cur;

  function automatic bit m_sready();
    return (reset === 1'b1) && (ap_start === 1'b1) && ((m_tail - m_head) < 8) && !m_replay;
  endfunction

  task automatic m_clear();
    m_head = 0; m_tail = 0; m_send = 0; m_end = 0;
    m_replay = 0; m_pend = 0; m_vld = 0; m_acc = 0;
    m_cur = '0;
  endtask

  task automatic m_step();
    int          sent0;
    int          off;
    bit          free, exit_ok, rew;
    logic [39:0] e;
    m_acc   = s_valid && m_sready();
    sent0   = m_send - m_head;
    exit_ok = m_replay && !m_pend && (m_send == m_end);
    if (ack_valid) begin
      off = (int'(ack_seq) - m_head) & 255;
      if (off < sent0) m_head += off + 1;
    end
    if (m_acc) begin
      m_mem[m_tail % 1024] = {s_dest_leaf, s_dest_port, s_data};
      m_tail++;
    end
    free = !m_vld || out_accept;
    rew  = resend || m_pend;
    if (resend) begin
      m_replay = 1;
      m_end    = m_tail;
    end else if (exit_ok) begin
      m_replay = 0;
    end
    if (rew && free) m_send = m_head;
    m_pend = rew && !free;
    if (free && (m_send < m_tail)) begin
      e     = m_mem[m_send % 1024];
      m_cur = {e[39:32], 8'(m_send), e[31:0]};
      m_vld = 1;
      m_send++;
    end else if (out_accept) begin
      m_vld = 0;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    chk("s_ready", 64'(s_ready), 64'(m_sready()));
    m_step();
    @(posedge clk);
    @(negedge clk);
    chk("dout", 64'(dout), 64'({m_vld, m_cur}));
    chk("inflight", 64'(inflight), 64'(m_tail - m_head));
  endtask

  task automatic idle();
    s_valid = 0; ack_valid = 0; resend = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    ap_start = 1; out_accept = 1;
    m_clear();
    @(negedge clk);
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_ready", 64'(s_ready), 64'(0));
    @(negedge clk);
    reset = 1;
  endtask

  task automatic send6();
    s_valid = 1; s_dest_leaf = 5'd5; s_dest_port = 3'd2;
    for (int i = 0; i < 6; i++) begin
      s_data = 32'h100 + 32'(i);
      cycle();
    end
    s_valid = 0;
    cycle();
  endtask

  initial begin
    logic [7:0] got_seq [$];
    int         exp_seq [5];
    bit         c_done;

    reset = 0; ap_start = 0; s_data = '0; s_dest_leaf = '0; s_dest_port = '0;
    s_valid = 0; out_accept = 0; ack_valid = 0; ack_seq = '0; resend = 0;
    m_clear();

    // 1: three payloads, one packet per cycle, 1-cycle latency
    do_reset();
    s_dest_leaf = 5'd5; s_dest_port = 3'd2; s_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'hA0 + 32'(i);
      cycle();
      chk("t1_vld", 64'(dout[48]), 64'(1));
      chk("t1_seq", 64'(dout[39:32]), 64'(i));
      chk("t1_data", 64'(dout[31:0]), 64'(32'hA0 + 32'(i)));
    end
    chk("t1_inflight", 64'(inflight), 64'(3));

    // 2: held packet stays bit-stable while out_accept is low
    s_data = 32'hB0;
    cycle();
    out_accept = 0; s_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      s_valid = 0;
      chk("t2_hold", 64'(dout), 64'({1'b1, 5'd5, 3'd2, 8'd3, 32'hB0}));
    end
    out_accept = 1;
    cycle();
    chk("t2_next_seq", 64'(dout[39:32]), 64'(4));
    chk("t2_next_data", 64'(dout[31:0]), 64'(32'hB1));

    // 3: full ring stalls, ack frees entries
    do_reset();
    s_valid = 1;
    for (int i = 0; i < 8; i++) begin
      s_data = $urandom;
      cycle();
    end
    chk("t3_full_ready", 64'(s_ready), 64'(0));
    chk("t3_full_inflight", 64'(inflight), 64'(8));
    s_data = 32'hC9;
    cycle();
    chk("t3_stall_inflight", 64'(inflight), 64'(8));
    s_valid = 0; ack_valid = 1; ack_seq = 8'd3;
    cycle();
    ack_valid = 0;
    chk("t3_ack_inflight", 64'(inflight), 64'(4));
    chk("t3_ack_ready", 64'(s_ready), 64'(1));

    // 4: ack 1 then resend replays 2..5, then SEND resumes with 6
    do_reset();
    send6();
    ack_valid = 1; ack_seq = 8'd1;
    cycle();
    ack_valid = 0; resend = 1;
    cycle();
    resend = 0;
    chk("t4_replay_ready", 64'(s_ready), 64'(0));
    got_seq.delete();
    if (dout[48]) got_seq.push_back(dout[39:32]);
    c_done = 0;
    s_data = 32'hC0;
    for (int i = 0; i < 8; i++) begin
      s_valid = !c_done;
      cycle();
      if (m_acc) c_done = 1;
      if (dout[48]) got_seq.push_back(dout[39:32]);
    end
    s_valid = 0;
    exp_seq = '{2, 3, 4, 5, 6};
    chk("t4_count", 64'(got_seq.size()), 64'(5));
    for (int k = 0; k < 5 && k < got_seq.size(); k++) begin
      chk("t4_seq", 64'(got_seq[k]), 64'(exp_seq[k]));
    end

    // 5: ack and resend together, stale ack ignored
    do_reset();
    send6();
    ack_valid = 1; ack_seq = 8'd3; resend = 1;
    cycle();
    resend = 0; ack_seq = 8'd1;
    chk("t5_first_seq", 64'(dout[39:32]), 64'(4));
    chk("t5_first_vld", 64'(dout[48]), 64'(1));
    chk("t5_inflight", 64'(inflight), 64'(2));
    cycle();
    ack_valid = 0;
    chk("t5_stale_inflight", 64'(inflight), 64'(2));
    chk("t5_seq5", 64'(dout[39:32]), 64'(5));

    // 6: asynchronous reset mid-replay
    do_reset();
    send6();
    resend = 1;
    cycle();
    resend = 0;
    cycle();
    #2 reset = 0;
    #1;
    chk("t6_dout", 64'(dout), 64'(0));
    chk("t6_inflight", 64'(inflight), 64'(0));
    chk("t6_ready", 64'(s_ready), 64'(0));
    m_clear();
    @(negedge clk);
    reset = 1;
    s_valid = 1; s_data = 32'hD0; s_dest_leaf = 5'd5; s_dest_port = 3'd2;
    cycle();
    s_valid = 0;
    chk("t6_vld", 64'(dout[48]), 64'(1));
    chk("t6_seq", 64'(dout[39:32]), 64'(0));
    chk("t6_data", 64'(dout[31:0]), 64'(32'hD0));

    // Randomized traffic with acks, resends, backpressure and occasional reset
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      ap_start    = ($urandom_range(0, 7) != 0);
      s_valid     = ($urandom_range(0, 2) != 0);
      s_data      = $urandom;
      s_dest_leaf = 5'($urandom);
      s_dest_port = 3'($urandom);
      out_accept  = ($urandom_range(0, 3) != 0);
      ack_valid   = ($urandom_range(0, 5) == 0);
      ack_seq     = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                : 8'(m_head - 1 + int'($urandom_range(0, 9)));
      resend      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1499) == 0) do_reset();
      else cycle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
